// File: rtl/shift_reg_universal_if.sv
// Control and data bundle for the universal shift register.
// The master side drives mode/enable/serial/parallel inputs; the slave side returns register state.
interface shift_reg_universal_if #(
   parameter int WIDTH = 4
) ();
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic             ser_in_msb;
   logic             ser_in_lsb;
   logic [WIDTH-1:0] par_in;
   logic [WIDTH-1:0] q;
   logic             ser_out_lsb;
   logic             ser_out_msb;
   logic [CW-1:0]    shift_count;
   logic             word_done;

   modport master (
      output en, mode, ser_in_msb, ser_in_lsb, par_in,
      input  q, ser_out_lsb, ser_out_msb, shift_count, word_done
   );

   modport slave (
      input  en, mode, ser_in_msb, ser_in_lsb, par_in,
      output q, ser_out_lsb, ser_out_msb, shift_count, word_done
   );
endinterface

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register: shifts, rotates, arithmetic shift, load, clear,
// plus a shift counter that pulses word_done after every WIDTH shifts.
module shift_reg_universal #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   shift_reg_universal_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROR   = 3'b100;
   localparam logic [2:0] M_ROL   = 3'b101;
   localparam logic [2:0] M_CLEAR = 3'b110;
   localparam logic [2:0] M_ASR   = 3'b111;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    cnt_r;
   logic             wd_r;
   logic             is_shift;
   logic             is_restart;

   always_comb begin
      q_nxt = q_r;
      case (bus.mode)
         M_HOLD:  q_nxt = q_r;
         M_SHR:   q_nxt = {bus.ser_in_msb, q_r[WIDTH-1:1]};
         M_SHL:   q_nxt = {q_r[WIDTH-2:0], bus.ser_in_lsb};
         M_LOAD:  q_nxt = bus.par_in;
         M_ROR:   q_nxt = {q_r[0], q_r[WIDTH-1:1]};
         M_ROL:   q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
         M_CLEAR: q_nxt = '0;
         M_ASR:   q_nxt = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
         default: q_nxt = q_r;
      endcase
   end

   assign is_shift   = (bus.mode == M_SHR) || (bus.mode == M_SHL) || (bus.mode == M_ROR) ||
                       (bus.mode == M_ROL) || (bus.mode == M_ASR);
   assign is_restart = (bus.mode == M_LOAD) || (bus.mode == M_CLEAR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r   <= RESET_VALUE;
         cnt_r <= '0;
         wd_r  <= 1'b0;
      end else if (!bus.en) begin
         wd_r <= 1'b0;
      end else begin
         q_r <= q_nxt;
         if (is_shift) begin
            // Wrap at the WIDTH-th shift so back-to-back words pulse every WIDTH cycles.
            if (cnt_r == CW'(WIDTH - 1)) begin
               cnt_r <= '0;
               wd_r  <= 1'b1;
            end else begin
               cnt_r <= cnt_r + 1'b1;
               wd_r  <= 1'b0;
            end
         end else if (is_restart) begin
            cnt_r <= '0;
            wd_r  <= 1'b0;
         end else begin
            wd_r <= 1'b0;
         end
      end
   end

   assign bus.q           = q_r;
   assign bus.ser_out_lsb = q_r[0];
   assign bus.ser_out_msb = q_r[WIDTH-1];
   assign bus.shift_count = cnt_r;
   assign bus.word_done   = wd_r;
endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal (WIDTH=4, RESET_VALUE=4'b1010).
// Stimulus pushes hand-computed expected state; a monitor pops and compares after each edge.
module tb_shift_reg_universal;
   localparam int WIDTH = 4;
   localparam logic [WIDTH-1:0] RV = 4'b1010;

   typedef struct {
      string      name;
      logic [3:0] q;
      logic [2:0] cnt;
      logic       wd;
   } exp_t;

   logic clk;
   logic rst_n;
   logic async_req;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   shift_reg_universal_if #(.WIDTH(WIDTH)) bus ();

   shift_reg_universal #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Monitor: checks after every rising edge, or right after an asynchronous reset assertion.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or async_req);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.q !== e.q || bus.shift_count !== e.cnt || bus.word_done !== e.wd ||
                bus.ser_out_lsb !== e.q[0] || bus.ser_out_msb !== e.q[3]) begin
               miscompares++;
               $display("FAIL %s: got q=%b cnt=%0d wd=%b lsb=%b msb=%b, want q=%b cnt=%0d wd=%b lsb=%b msb=%b",
                        e.name, bus.q, bus.shift_count, bus.word_done, bus.ser_out_lsb, bus.ser_out_msb,
                        e.q, e.cnt, e.wd, e.q[0], e.q[3]);
            end
         end
      end
   end

   task automatic drive(input string nm, input logic r, input logic e, input logic [2:0] m,
                        input logic smsb, input logic slsb, input logic [3:0] p,
                        input logic [3:0] eq, input logic [2:0] ec, input logic ew);
      exp_t x;
      @(negedge clk);
      rst_n          = r;
      bus.en         = e;
      bus.mode       = m;
      bus.ser_in_msb = smsb;
      bus.ser_in_lsb = slsb;
      bus.par_in     = p;
      x.name = nm; x.q = eq; x.cnt = ec; x.wd = ew;
      sb.push_back(x);
   endtask

   task automatic async_reset(input string nm);
      exp_t x;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      x.name = nm; x.q = RV; x.cnt = 3'd0; x.wd = 1'b0;
      sb.push_back(x);
      async_req = ~async_req;
      #3;
   endtask

   initial begin
      vectors = 0; miscompares = 0; async_req = 1'b0;
      rst_n = 1'b0;
      bus.en = 1'b1; bus.mode = 3'b011; bus.ser_in_msb = 1'b1; bus.ser_in_lsb = 1'b1; bus.par_in = 4'b1111;

      // 1: reset held while clocking with active inputs, then async assertion mid-cycle
      drive("rst_hold0", 0, 1, 3'b011, 1, 1, 4'b1111, RV, 0, 0);
      drive("rst_hold1", 0, 1, 3'b001, 1, 1, 4'b0000, RV, 0, 0);
      drive("rst_hold2", 0, 1, 3'b010, 0, 1, 4'b0101, RV, 0, 0);
      drive("rst_rel_load", 1, 1, 3'b011, 0, 0, 4'b0110, 4'b0110, 0, 0);
      async_reset("rst_async");

      // 2: parallel load then serial out LSB-first
      drive("p2s_load", 1, 1, 3'b011, 0, 0, 4'b1101, 4'b1101, 0, 0);
      drive("p2s_sh1", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0110, 1, 0);
      drive("p2s_sh2", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0011, 2, 0);
      drive("p2s_sh3", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0001, 3, 0);
      drive("p2s_sh4", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0000, 0, 1);
      drive("p2s_hold", 1, 1, 3'b000, 1, 1, 4'b1111, 4'b0000, 0, 0);

      // 3: serial-in capture, two back-to-back words
      drive("s2p_b1", 1, 1, 3'b001, 1, 0, 4'b0000, 4'b1000, 1, 0);
      drive("s2p_b2", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0100, 2, 0);
      drive("s2p_b3", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0010, 3, 0);
      drive("s2p_b4", 1, 1, 3'b001, 1, 0, 4'b0000, 4'b1001, 0, 1);
      drive("s2p_w2b1", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0100, 1, 0);
      drive("s2p_w2b2", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0010, 2, 0);
      drive("s2p_w2b3", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0001, 3, 0);
      drive("s2p_w2b4", 1, 1, 3'b001, 0, 0, 4'b0000, 4'b0000, 0, 1);

      // 4: rotates, arithmetic shift, left shift (mixed directions all count)
      drive("rot_load", 1, 1, 3'b011, 0, 0, 4'b1001, 4'b1001, 0, 0);
      drive("rol", 1, 1, 3'b101, 0, 0, 4'b0000, 4'b0011, 1, 0);
      drive("ror", 1, 1, 3'b100, 0, 0, 4'b0000, 4'b1001, 2, 0);
      drive("asr1", 1, 1, 3'b111, 0, 0, 4'b0000, 4'b1100, 3, 0);
      drive("asr2", 1, 1, 3'b111, 0, 0, 4'b0000, 4'b1110, 0, 1);
      drive("shl1", 1, 1, 3'b010, 0, 1, 4'b0000, 4'b1101, 1, 0);

      // 5: enable gating, load and clear restart the count
      drive("en_load", 1, 1, 3'b011, 0, 0, 4'b0101, 4'b0101, 0, 0);
      drive("en_sh1", 1, 1, 3'b001, 1, 0, 4'b0000, 4'b1010, 1, 0);
      drive("en_sh2", 1, 1, 3'b001, 1, 0, 4'b0000, 4'b1101, 2, 0);
      drive("en_off1", 1, 0, 3'b001, 1, 0, 4'b0000, 4'b1101, 2, 0);
      drive("en_off2", 1, 0, 3'b011, 1, 0, 4'b1111, 4'b1101, 2, 0);
      drive("en_off3", 1, 0, 3'b110, 1, 0, 4'b0000, 4'b1101, 2, 0);
      drive("en_reload", 1, 1, 3'b011, 0, 0, 4'b0011, 4'b0011, 0, 0);
      drive("en_shl", 1, 1, 3'b010, 0, 0, 4'b0000, 4'b0110, 1, 0);
      drive("clear", 1, 1, 3'b110, 1, 1, 4'b1111, 4'b0000, 0, 0);

      // 6: reset mid-word aborts the word
      drive("mw_sh1", 1, 1, 3'b010, 0, 1, 4'b0000, 4'b0001, 1, 0);
      drive("mw_sh2", 1, 1, 3'b010, 0, 1, 4'b0000, 4'b0011, 2, 0);
      drive("mw_sh3", 1, 1, 3'b010, 0, 1, 4'b0000, 4'b0111, 3, 0);
      async_reset("mw_reset");
      drive("mw_r_sh1", 1, 1, 3'b010, 0, 0, 4'b0000, 4'b0100, 1, 0);
      drive("mw_r_sh2", 1, 1, 3'b010, 0, 0, 4'b0000, 4'b1000, 2, 0);
      drive("mw_r_sh3", 1, 1, 3'b010, 0, 0, 4'b0000, 4'b0000, 3, 0);
      drive("mw_r_sh4", 1, 1, 3'b010, 0, 0, 4'b0000, 4'b0000, 0, 1);
      async_reset("wd_drop_on_reset");
      drive("post_rst_hold", 1, 1, 3'b000, 0, 0, 4'b0000, RV, 0, 0);

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d expected entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
